// File: rtl/blank_scheduler.sv
// Blanking timing scheduler: walks an h/v symbol-time raster built from shadowed
// MSA timing and tells blank_mapper which blanking phase each cycle belongs to.
module blank_scheduler #(
  parameter int CNT_W  = 16,
  parameter int BS_LEN = 4,
  parameter int BE_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             td_vid_en,
  input  logic [1:0]       td_lane_count,
  input  logic [CNT_W-1:0] td_h_total,
  input  logic [CNT_W-1:0] td_h_active,
  input  logic [CNT_W-1:0] td_v_total,
  input  logic [CNT_W-1:0] td_v_active,
  output logic             sched_blank_en,
  output logic             sched_blank_id,
  output logic [1:0]       sched_blank_state,
  output logic             sched_active_en,
  output logic             sched_cfg_err
);

  // Two spare bits keep the h-position sums from wrapping for any 16-bit timing.
  localparam int SUM_W = CNT_W + 2;

  typedef enum logic {IDLE, RUN} fsm_t;
  typedef enum logic [1:0] {
    ST_BLANK = 2'b00,
    ST_BS    = 2'b01,
    ST_START = 2'b10,
    ST_BE    = 2'b11
  } blank_state_t;

  // VBID, Mvid and Maud repeated per lane, serialised over the active lanes.
  function automatic logic [SUM_W-1:0] start_len(input logic [1:0] lanes);
    case (lanes)
      2'b00:   return SUM_W'(12);
      2'b01:   return SUM_W'(6);
      default: return SUM_W'(3);
    endcase
  endfunction

  fsm_t             state, nxt_state;
  logic             vid_en_q;
  logic [CNT_W-1:0] h_cnt, nxt_h;
  logic [CNT_W-1:0] v_cnt, nxt_v;
  logic             cfg_err, nxt_err;
  logic             load_sh;

  logic [1:0]       sh_lanes;
  logic [CNT_W-1:0] sh_h_total, sh_h_active, sh_v_total, sh_v_active;

  logic             dec_blank_en, dec_id, dec_active_en;
  blank_state_t     dec_state, state_q;

  logic             vid_rise, in_cfg_ok, h_last, v_last;
  logic [SUM_W-1:0] in_min_h_total;

  assign vid_rise       = td_vid_en & ~vid_en_q;
  assign in_min_h_total = SUM_W'(td_h_active) + SUM_W'(BS_LEN + BE_LEN + 1)
                        + start_len(td_lane_count);
  assign in_cfg_ok      = (td_h_active != '0) && (td_v_active != '0)
                        && (td_v_total > td_v_active)
                        && (SUM_W'(td_h_total) >= in_min_h_total);
  assign h_last         = (h_cnt == sh_h_total - CNT_W'(1));
  assign v_last         = (v_cnt == sh_v_total - CNT_W'(1));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    nxt_state = state;
    nxt_h     = h_cnt;
    nxt_v     = v_cnt;
    nxt_err   = cfg_err & td_vid_en;
    load_sh   = 1'b0;
    unique case (state)
      IDLE: begin
        nxt_h = '0;
        nxt_v = '0;
        if (vid_rise) begin
          load_sh = 1'b1;
          if (in_cfg_ok) begin
            nxt_state = RUN;
            nxt_v     = td_v_active;  // first VBlank line, so MSA goes out first
          end else begin
            nxt_err = 1'b1;
          end
        end
      end
      RUN: begin
        if (!td_vid_en) begin
          nxt_state = IDLE;
          nxt_h     = '0;
          nxt_v     = '0;
        end else if (h_last) begin
          nxt_h = '0;
          if (v_last) begin
            nxt_v   = '0;
            load_sh = 1'b1;
            if (!in_cfg_ok) begin
              nxt_state = IDLE;
              nxt_err   = 1'b1;
            end
          end else begin
            nxt_v = v_cnt + CNT_W'(1);
          end
        end else begin
          nxt_h = h_cnt + CNT_W'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  logic [SUM_W-1:0] h_ext, bs_end, st_end, be_start;
  logic             active_line, be_line;

  assign h_ext       = SUM_W'(h_cnt);
  assign bs_end      = SUM_W'(sh_h_active) + SUM_W'(BS_LEN);
  assign st_end      = bs_end + start_len(sh_lanes);
  assign be_start    = SUM_W'(sh_h_total) - SUM_W'(BE_LEN);
  assign active_line = (v_cnt < sh_v_active);
  // BE only precedes an active line: any non-last active line, or the frame's last line.
  assign be_line     = (v_cnt < sh_v_active - CNT_W'(1)) || v_last;

  always_comb begin
    dec_blank_en  = 1'b0;
    dec_id        = 1'b0;
    dec_active_en = 1'b0;
    dec_state     = ST_BLANK;
    if (state == RUN && td_vid_en) begin
      dec_id = active_line;
      if (active_line && h_cnt < sh_h_active) begin
        dec_active_en = 1'b1;
      end else begin
        dec_blank_en = 1'b1;
        if (h_cnt < sh_h_active)          dec_state = ST_BLANK;
        else if (h_ext < bs_end)          dec_state = ST_BS;
        else if (h_ext < st_end)          dec_state = ST_START;
        else if (h_ext >= be_start && be_line) dec_state = ST_BE;
        else                              dec_state = ST_BLANK;
      end
    end
  end

  // NOTE: always_ff blocks use non-blocking assignments only, so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vid_en_q <= 1'b0;
      h_cnt    <= '0;
      v_cnt    <= '0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= nxt_state;
      vid_en_q <= td_vid_en;
      h_cnt    <= nxt_h;
      v_cnt    <= nxt_v;
      cfg_err  <= nxt_err;
    end
  end

  // NOTE: the shadow timing registers are plain flops, so they take a reset value
  // of zero like the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_lanes    <= '0;
      sh_h_total  <= '0;
      sh_h_active <= '0;
      sh_v_total  <= '0;
      sh_v_active <= '0;
    end else if (load_sh) begin
      sh_lanes    <= td_lane_count;
      sh_h_total  <= td_h_total;
      sh_h_active <= td_h_active;
      sh_v_total  <= td_v_total;
      sh_v_active <= td_v_active;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched_blank_en  <= 1'b0;
      sched_blank_id  <= 1'b0;
      sched_active_en <= 1'b0;
      state_q         <= ST_BLANK;
    end else begin
      sched_blank_en  <= dec_blank_en;
      sched_blank_id  <= dec_id;
      sched_active_en <= dec_active_en;
      state_q         <= dec_state;
    end
  end

  assign sched_blank_state = state_q;
  assign sched_cfg_err     = cfg_err;

endmodule

// File: tb/tb_blank_scheduler.sv
// Self-checking bench for blank_scheduler: directed raster checks with literal
// expectations plus randomized timing against a frame-position reference model.
module tb_blank_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        td_vid_en = 1'b0;
  logic [1:0]  td_lane_count = 2'b00;
  logic [15:0] td_h_total = '0;
  logic [15:0] td_h_active = '0;
  logic [15:0] td_v_total = '0;
  logic [15:0] td_v_active = '0;
  logic        sched_blank_en, sched_blank_id, sched_active_en, sched_cfg_err;
  logic [1:0]  sched_blank_state;

  int errors = 0;
  int checks = 0;

  blank_scheduler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .td_vid_en        (td_vid_en),
    .td_lane_count    (td_lane_count),
    .td_h_total       (td_h_total),
    .td_h_active      (td_h_active),
    .td_v_total       (td_v_total),
    .td_v_active      (td_v_active),
    .sched_blank_en   (sched_blank_en),
    .sched_blank_id   (sched_blank_id),
    .sched_blank_state(sched_blank_state),
    .sched_active_en  (sched_active_en),
    .sched_cfg_err    (sched_cfg_err)
  );

  always #5 clk = ~clk;

  // {cfg_err, active_en, blank_en, id, state[1:0]}
  logic [5:0] dut_vec;
  assign dut_vec = {sched_cfg_err, sched_active_en, sched_blank_en, sched_blank_id,
                    sched_blank_state};

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int start_len(input int lanes);
    return (lanes == 0) ? 12 : (lanes == 1) ? 6 : 3;
  endfunction

  function automatic bit cfg_ok(input int ht, input int ha, input int vt, input int va,
                                input int lanes);
    return ha >= 1 && va >= 1 && vt > va && ht >= ha + 4 + start_len(lanes) + 4 + 1;
  endfunction

  // Expected {active_en, blank_en, id, state} for raster position (h, v).
  function automatic logic [4:0] raster(input int h, input int v, input int ht,
                                        input int ha, input int vt, input int va,
                                        input int lanes);
    bit         act_line = (v < va);
    logic [1:0] st;
    if (h < ha) return act_line ? 5'b10100 : 5'b01000;
    if (h < ha + 4)                                st = 2'b01;
    else if (h < ha + 4 + start_len(lanes))        st = 2'b10;
    else if (h >= ht - 4 && ((v + 1) % vt) < va)   st = 2'b11;
    else                                           st = 2'b00;
    return {2'b01, act_line, st};
  endfunction

  bit         m_run = 0, m_err = 0, m_prev = 0;
  int         m_pos = 0;
  int         sh_ht = 0, sh_ha = 0, sh_vt = 0, sh_va = 0, sh_ln = 0;
  logic [5:0] m_exp = '0;

  task automatic model_load();
    sh_ht = int'(td_h_total);
    sh_ha = int'(td_h_active);
    sh_vt = int'(td_v_total);
    sh_va = int'(td_v_active);
    sh_ln = int'(td_lane_count);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run = 0; m_err = 0; m_prev = 0; m_pos = 0; m_exp = '0;
      sh_ht = 0; sh_ha = 0; sh_vt = 0; sh_va = 0; sh_ln = 0;
    end else begin
      logic [4:0] o;
      bit         rise;
      o = '0;
      if (m_run && td_vid_en)
        o = raster(m_pos % sh_ht, m_pos / sh_ht, sh_ht, sh_ha, sh_vt, sh_va, sh_ln);
      rise   = td_vid_en && !m_prev;
      m_prev = td_vid_en;
      if (!td_vid_en) begin
        m_run = 0;
        m_err = 0;
      end else if (m_run) begin
        if (m_pos == sh_ht * sh_vt - 1) begin
          model_load();
          m_pos = 0;
          if (!cfg_ok(sh_ht, sh_ha, sh_vt, sh_va, sh_ln)) begin
            m_run = 0;
            m_err = 1;
          end
        end else begin
          m_pos++;
        end
      end else if (rise) begin
        model_load();
        if (cfg_ok(sh_ht, sh_ha, sh_vt, sh_va, sh_ln)) begin
          m_run = 1;
          m_pos = sh_va * sh_ht;
        end else begin
          m_err = 1;
        end
      end
      m_exp = {m_err, o};
    end
  end

  always @(negedge clk) if (rst_n) check("model", dut_vec, m_exp);

  // ---------------- stimulus ----------------
  function automatic logic [5:0] lit(input byte c, input logic id);
    if (c == "A") return 6'b010100;
    return {3'b001, id, 2'(c - 8'd48)};
  endfunction

  task automatic set_cfg(input logic [1:0] ln, input int ht, input int ha,
                         input int vt, input int va);
    td_lane_count = ln;
    td_h_total    = 16'(ht);
    td_h_active   = 16'(ha);
    td_v_total    = 16'(vt);
    td_v_active   = 16'(va);
  endtask

  task automatic rand_cfg();
    set_cfg(2'($urandom_range(0, 3)), $urandom_range(14, 40), $urandom_range(0, 16),
            $urandom_range(1, 5), $urandom_range(0, 4));
    if ($urandom_range(0, 19) == 0) td_h_active = 16'hFFFF;
  endtask

  string l2 = "00000000111122200000";
  string l3 = "00000000111122203333";
  string l0 = "AAAAAAAA1111222000003333";
  string l1 = "AAAAAAAA1111222000000000";

  initial begin
    #23;
    check("reset outputs", dut_vec, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;

    // 4 lanes, 20x4 raster with 8x2 active: exactly the minimum legal h_total.
    @(posedge clk); #2;
    set_cfg(2'b11, 20, 8, 4, 2);
    td_vid_en = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 88; k++) begin
      logic [5:0] e;
      @(posedge clk); #2;
      if (k == 10) td_h_total = 16'd24;  // must not apply until the frame wraps
      @(negedge clk);
      if (k < 20)      e = lit(l2[k], 1'b0);
      else if (k < 40) e = lit(l3[k - 20], 1'b0);
      else if (k < 64) e = lit(l0[k - 40], 1'b1);
      else if (k < 88) e = lit(l1[k - 64], 1'b1);
      else             e = 6'b001000;
      check($sformatf("raster k=%0d", k), dut_vec, e);
    end

    // Abort at v=0, h=5 of the next frame (lines are now 24 long).
    for (int k = 89; k <= 141; k++) @(posedge clk);
    @(negedge clk);
    check("v0 h5 active", dut_vec, 6'b010100);
    td_vid_en = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort outputs", dut_vec, 6'b000000);
    repeat (2) @(posedge clk);
    #2 td_vid_en = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("restart v2 h0", dut_vec, 6'b001000);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("restart v2 h8 BS", dut_vec, 6'b001001);

    // 1 lane: 8+4+12+4+1 = 29 > 20 -> configuration error.
    @(posedge clk); #2 td_vid_en = 1'b0;
    @(posedge clk); #2;
    set_cfg(2'b00, 20, 8, 4, 2);
    td_vid_en = 1'b1;
    @(posedge clk); @(negedge clk);
    check("cfg_err 1 lane", dut_vec, 6'b100000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("cfg_err sticky", dut_vec, 6'b100000);
    @(posedge clk); #2 td_vid_en = 1'b0;
    @(posedge clk); @(negedge clk);
    check("cfg_err clears", dut_vec, 6'b000000);

    // 4 lanes one cycle short of the minimum line length.
    @(posedge clk); #2;
    set_cfg(2'b10, 19, 8, 4, 2);
    td_vid_en = 1'b1;
    @(posedge clk); @(negedge clk);
    check("cfg_err h_total-1", dut_vec, 6'b100000);

    // Asynchronous reset mid-frame.
    @(posedge clk); #2 td_vid_en = 1'b0;
    @(posedge clk); #2;
    set_cfg(2'b11, 20, 8, 4, 2);
    td_vid_en = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b0;
    #1 check("async reset", dut_vec, 6'b000000);
    @(posedge clk); @(negedge clk);
    check("held in reset", dut_vec, 6'b000000);
    #1 rst_n = 1'b1;

    // Randomized timing, enables and mid-frame reprogramming against the model.
    for (int it = 0; it < 60; it++) begin
      @(posedge clk); #2 td_vid_en = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #2 rand_cfg();
      td_vid_en = 1'b1;
      for (int n = $urandom_range(50, 500); n > 0; n--) begin
        int r;
        @(posedge clk); #2;
        r = $urandom_range(0, 299);
        if (r == 0)                      rand_cfg();
        else if (r == 1)                 td_vid_en = 1'b0;
        else if (!td_vid_en && r < 30)   td_vid_en = 1'b1;
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
